// File: rtl/alu_pkg.sv
// Shared constants and payload types for the execute-stage ALU issue path.
package alu_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned SHAMT_W  = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned RD_W     = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [ALU_OP_W-1:0] ADD_OP  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] SLL_OP  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] SLT_OP  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] SLTU_OP = 4'b0011;
  localparam logic [ALU_OP_W-1:0] XOR_OP  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] SRL_OP  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] OR_OP   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] AND_OP  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] SUB_OP  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] SRA_OP  = 4'b1101;

  // out_flags = {carry, overflow, zero}
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [RD_W-1:0]     rd;
    logic                illegal;
  } e1_t;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   result;
    logic [FLAG_W-1:0] flags;
    logic              illegal;
  } e2_t;

endpackage

// File: rtl/alu_64_bit.sv
// Combinational 64-bit ALU; carry/overflow/zero are reported only for ADD and SUB.
module alu_64_bit
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  input  logic [ALU_OP_W-1:0] i_op,
  output logic [XLEN-1:0]     o_result,
  output logic                o_carry,
  output logic                o_overflow,
  output logic                o_zero
);

  logic [XLEN:0] w_sum;

  // SUB carry is the no-borrow flag of a + ~b + 1
  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    o_zero     = 1'b0;
    w_sum      = '0;
    case (i_op)
      ADD_OP: begin
        w_sum      = {1'b0, i_a} + {1'b0, i_b};
        o_result   = w_sum[XLEN-1:0];
        o_carry    = w_sum[XLEN];
        o_overflow = (i_a[XLEN-1] == i_b[XLEN-1]) && (o_result[XLEN-1] != i_a[XLEN-1]);
        o_zero     = (o_result == '0);
      end
      SUB_OP: begin
        w_sum      = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
        o_result   = w_sum[XLEN-1:0];
        o_carry    = w_sum[XLEN];
        o_overflow = (i_a[XLEN-1] != i_b[XLEN-1]) && (o_result[XLEN-1] != i_a[XLEN-1]);
        o_zero     = (o_result == '0);
      end
      SLL_OP:  o_result = i_a << i_b[SHAMT_W-1:0];
      SLT_OP:  o_result = XLEN'($signed(i_a) < $signed(i_b));
      SLTU_OP: o_result = XLEN'(i_a < i_b);
      XOR_OP:  o_result = i_a ^ i_b;
      SRL_OP:  o_result = i_a >> i_b[SHAMT_W-1:0];
      OR_OP:   o_result = i_a | i_b;
      AND_OP:  o_result = i_a & i_b;
      SRA_OP:  o_result = $signed(i_a) >>> i_b[SHAMT_W-1:0];
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_decode.sv
// Combinational RV64I OP/OP-IMM decode into ALU opcode, operand-b source and legality.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic [6:0]          i_funct7,
  output logic [ALU_OP_W-1:0] o_alu_op_c,
  output logic                o_use_imm_c,
  output logic                o_is_shift_c,
  output logic                o_illegal_c
);

  logic w_is_op;
  logic w_is_opi;
  logic w_sel;
  logic w_legal;
  logic w_addsub_or_sr;

  always_comb begin
    w_is_op        = (i_opcode == OPC_OP);
    w_is_opi       = (i_opcode == OPC_OP_IMM);
    w_addsub_or_sr = (i_funct3 == 3'b000) || (i_funct3 == 3'b101);
    o_is_shift_c   = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    o_use_imm_c    = w_is_opi;
    w_sel          = 1'b0;
    w_legal        = 1'b0;
    if (w_is_op) begin
      w_sel   = i_funct7[5] && w_addsub_or_sr;
      w_legal = (i_funct7 == 7'b0000000) ||
                ((i_funct7 == 7'b0100000) && w_addsub_or_sr);
    end else if (w_is_opi) begin
      // funct7[0] is shamt[5] on RV64 immediate shifts
      w_sel = i_funct7[5] && (i_funct3 == 3'b101);
      case (i_funct3)
        3'b001:  w_legal = (i_funct7[6:1] == 6'b000000);
        3'b101:  w_legal = ({i_funct7[6], i_funct7[4:1]} == 5'b00000);
        default: w_legal = 1'b1;
      endcase
    end
    o_illegal_c = !w_legal;
    o_alu_op_c  = w_legal ? {w_sel, i_funct3} : ADD_OP;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage execute issue: E1 drives the external ALU, E2 holds result/flags for writeback.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [XLEN-1:0]     in_rs1_val,
  input  logic [XLEN-1:0]     in_rs2_val,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [RD_W-1:0]     in_rd,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_carry,
  input  logic                alu_overflow,
  input  logic                alu_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RD_W-1:0]     out_rd,
  output logic [XLEN-1:0]     out_result,
  output logic [FLAG_W-1:0]   out_flags,
  output logic                out_illegal
);

  e1_t                 r_e1;
  e2_t                 r_e2;
  e1_t                 w_e1_nxt;
  logic                r_e1_valid;
  logic                r_e2_valid;
  logic                w_accept;
  logic                w_e2_load;
  logic [ALU_OP_W-1:0] w_dec_op;
  logic                w_use_imm;
  logic                w_is_shift;
  logic                w_illegal;
  logic [XLEN-1:0]     w_b_raw;
  logic [FLAG_W-1:0]   w_flags;

  alu_op_decode u_dec (
    .i_opcode     (in_opcode),
    .i_funct3     (in_funct3),
    .i_funct7     (in_funct7),
    .o_alu_op_c   (w_dec_op),
    .o_use_imm_c  (w_use_imm),
    .o_is_shift_c (w_is_shift),
    .o_illegal_c  (w_illegal)
  );

  // Illegal ops travel as ADD 0,0 so the ALU sees a benign operation
  always_comb begin
    w_b_raw          = w_use_imm ? in_imm : in_rs2_val;
    w_e1_nxt         = '0;
    w_e1_nxt.rd      = in_rd;
    w_e1_nxt.illegal = w_illegal;
    if (!w_illegal) begin
      w_e1_nxt.op = w_dec_op;
      w_e1_nxt.a  = in_rs1_val;
      w_e1_nxt.b  = w_is_shift ? XLEN'(w_b_raw[SHAMT_W-1:0]) : w_b_raw;
    end
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_C] = alu_carry;
    w_flags[FLAG_V] = alu_overflow;
    w_flags[FLAG_Z] = alu_zero;
  end

  assign w_e2_load = r_e1_valid && (!r_e2_valid || out_ready);
  assign in_ready  = !r_e1_valid || w_e2_load;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e1_valid <= 1'b0;
      r_e2_valid <= 1'b0;
    end else if (flush) begin
      r_e1_valid <= 1'b0;
      r_e2_valid <= 1'b0;
    end else begin
      if (w_accept)       r_e1_valid <= 1'b1;
      else if (w_e2_load) r_e1_valid <= 1'b0;
      if (w_e2_load)      r_e2_valid <= 1'b1;
      else if (out_ready) r_e2_valid <= 1'b0;
    end
  end

  // Payload registers move only on real transfers; a flush cycle is never a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e1 <= '0;
      r_e2 <= '0;
    end else if (!flush) begin
      if (w_accept) r_e1 <= w_e1_nxt;
      if (w_e2_load) begin
        r_e2.rd      <= r_e1.rd;
        r_e2.illegal <= r_e1.illegal;
        r_e2.result  <= r_e1.illegal ? '0 : alu_result;
        r_e2.flags   <= r_e1.illegal ? '0 : w_flags;
      end
    end
  end

  assign alu_a       = r_e1.a;
  assign alu_b       = r_e1.b;
  assign alu_op      = r_e1.op;
  assign out_valid   = r_e2_valid;
  assign out_rd      = r_e2.rd;
  assign out_result  = r_e2.result;
  assign out_flags   = r_e2.flags;
  assign out_illegal = r_e2.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl driving a real alu_64_bit, with an ISA-level reference model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam logic [6:0] T_OP  = 7'b0110011;
  localparam logic [6:0] T_OPI = 7'b0010011;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic [63:0] in_imm;
  logic [4:0]  in_rd;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_result;
  logic [2:0]  out_flags;
  logic        out_illegal;

  typedef struct {
    logic [63:0] result;
    logic [2:0]  flags;
    logic        illegal;
    logic [4:0]  rd;
    bit          spurious;
  } rec_t;

  rec_t pend_q[$];
  rec_t exp_done[$];
  rec_t obs_done[$];
  rec_t mon_o;
  rec_t mon_s;
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_flags(out_flags), .out_illegal(out_illegal)
  );

  alu_64_bit u_alu (
    .i_a(alu_a), .i_b(alu_b), .i_op(alu_op),
    .o_result(alu_result), .o_carry(alu_carry), .o_overflow(alu_overflow), .o_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV64I semantics straight from the ISA rules, flags from exact arithmetic
  function automatic rec_t ref_model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [63:0] a, input logic [63:0] rs2,
                                     input logic [63:0] imm, input logic [4:0] rd);
    rec_t r;
    logic [63:0] b;
    logic signed [63:0] sa;
    logic signed [64:0] exact;
    logic [64:0] uwide;
    logic legal;
    int sh;
    r = '{default: 0};
    r.rd = rd;
    if (opc == T_OP) legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (opc == T_OPI) begin
      if (f3 == 3'd1)      legal = (f7[6:1] == 6'd0);
      else if (f3 == 3'd5) legal = (f7[6:1] == 6'd0) || (f7[6:1] == 6'b010000);
      else                 legal = 1'b1;
    end else legal = 1'b0;
    r.illegal = !legal;
    if (!legal) return r;
    b  = (opc == T_OP) ? rs2 : imm;
    sh = int'(b[5:0]);
    sa = a;
    case (f3)
      3'd0: begin
        if (opc == T_OP && f7[5]) begin
          r.result = a - b;
          exact    = $signed({a[63], a}) - $signed({b[63], b});
          r.flags  = {a >= b, exact[64] != exact[63], r.result == 64'd0};
        end else begin
          r.result = a + b;
          uwide    = {1'b0, a} + {1'b0, b};
          exact    = $signed({a[63], a}) + $signed({b[63], b});
          r.flags  = {uwide[64], exact[64] != exact[63], r.result == 64'd0};
        end
      end
      3'd1: r.result = a << sh;
      3'd2: r.result = (sa < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: r.result = (a < b) ? 64'd1 : 64'd0;
      3'd4: r.result = a ^ b;
      3'd5: r.result = f7[5] ? 64'(sa >>> sh) : (a >> sh);
      3'd6: r.result = a | b;
      default: r.result = a & b;
    endcase
    return r;
  endfunction

  // Records accepted ops (as expected) and delivered ops (as observed)
  always @(negedge clk) begin
    if (rst === 1'b1 || flush === 1'b1) begin
      pend_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        mon_o = '{result: out_result, flags: out_flags, illegal: out_illegal, rd: out_rd, spurious: 0};
        obs_done.push_back(mon_o);
        if (pend_q.size() > 0) exp_done.push_back(pend_q.pop_front());
        else begin
          mon_s = '{default: 0};
          mon_s.spurious = 1;
          exp_done.push_back(mon_s);
        end
      end
      if (in_valid && in_ready)
        pend_q.push_back(ref_model(in_opcode, in_funct3, in_funct7, in_rs1_val, in_rs2_val, in_imm, in_rd));
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                          input logic [4:0] rd);
    int n;
    in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rs1_val = a; in_rs2_val = b; in_imm = im; in_rd = rd;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout in_ready=%0b after %0d cycles", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_op(output logic [6:0] opc, output logic [2:0] f3, output logic [6:0] f7,
                         output logic [63:0] a, output logic [63:0] b, output logic [63:0] im);
    int     sel;
    logic [11:0] i12;
    sel = $urandom_range(0, 9);
    opc = (sel == 0) ? 7'($urandom) : (sel < 6) ? T_OP : T_OPI;
    f3  = 3'($urandom);
    sel = $urandom_range(0, 4);
    f7  = (sel < 2) ? 7'h00 : (sel < 4) ? 7'h20 : 7'($urandom);
    if ($urandom_range(0, 3) == 0) f7[0] = 1'b1;
    a   = {$urandom, $urandom};
    b   = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 20));
    i12 = 12'($urandom);
    im  = {{52{i12[11]}}, i12};
  endtask

  task automatic drain_queues(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (pend_q.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctl out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    total++;
    if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_op !== 4'd0) begin
      bad++;
      $display("FAIL reset_alu a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op);
    end
    total++;
    if (out_result !== 64'd0 || out_rd !== 5'd0 || out_flags !== 3'd0 || out_illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_out res=%h rd=%0d fl=%b ill=%b want 0", out_result, out_rd, out_flags, out_illegal);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    // ADD 5+7
    drive_op(T_OP, 3'd0, 7'h00, 64'd5, 64'd7, 64'd0, 5'd3);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_latency_early out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'd12 || out_rd !== 5'd3 || out_flags !== 3'b000) begin
      bad++;
      $display("FAIL add v=%b res=%0d rd=%0d fl=%b want 1/12/3/000", out_valid, out_result, out_rd, out_flags);
    end
    // SUB equal operands
    drive_op(T_OP, 3'd0, 7'h20, 64'h10, 64'h10, 64'd0, 5'd4);
    total++;
    if (alu_op !== 4'b1000) begin bad++; $display("FAIL sub_op got %b want 1000", alu_op); end
    @(posedge clk); #1;
    total++;
    if (out_result !== 64'd0 || out_flags !== 3'b101 || out_rd !== 5'd4) begin
      bad++;
      $display("FAIL sub res=%h fl=%b rd=%0d want 0/101/4", out_result, out_flags, out_rd);
    end
    // SRAI by imm 0x43 -> shamt 3
    drive_op(T_OPI, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'hFFFF, 64'h43, 5'd5);
    total++;
    if (alu_op !== 4'b1101 || alu_b !== 64'd3) begin
      bad++;
      $display("FAIL sra_issue op=%b b=%h want 1101/3", alu_op, alu_b);
    end
    @(posedge clk); #1;
    total++;
    if (out_result !== 64'hF000_0000_0000_0000 || out_flags !== 3'b000 || out_illegal !== 1'b0) begin
      bad++;
      $display("FAIL sra res=%h fl=%b ill=%b want f000000000000000/000/0", out_result, out_flags, out_illegal);
    end
    // Branch opcode is illegal here
    drive_op(7'b1100011, 3'd0, 7'h00, 64'h1234, 64'h5678, 64'd0, 5'd6);
    total++;
    if (alu_op !== 4'd0 || alu_a !== 64'd0 || alu_b !== 64'd0) begin
      bad++;
      $display("FAIL illegal_issue op=%b a=%h b=%h want 0", alu_op, alu_a, alu_b);
    end
    @(posedge clk); #1;
    total++;
    if (out_illegal !== 1'b1 || out_result !== 64'd0 || out_flags !== 3'b000 || out_rd !== 5'd6) begin
      bad++;
      $display("FAIL illegal ill=%b res=%h fl=%b rd=%0d want 1/0/000/6", out_illegal, out_result, out_flags, out_rd);
    end
    @(posedge clk); #1;
    pend_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_back_to_back();
    int stall0;
    int n_out;
    rec_t e;
    rec_t o;
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [63:0] a, b, im;
    stall0 = stall_cnt;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          f3 = 3'(i * 2 + 1);
          opc = T_OP; f7 = 7'h00; a = {$urandom, $urandom}; b = {$urandom, $urandom}; im = '0;
          drive_op(opc, f3, f7, a, b, im, 5'(10 + i));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain_queues(50);
    total++;
    if (stall_cnt == stall0) begin bad++; $display("FAIL b2b_stall in_ready never dropped, stalls=%0d", stall_cnt - stall0); end
    n_out = obs_done.size();
    total++;
    if (n_out != 4 || pend_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got %0d outputs pending %0d want 4/0", n_out, pend_q.size());
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      e = exp_done.pop_front();
      o = obs_done.pop_front();
      total++;
      if (e.spurious || o.rd !== e.rd || o.result !== e.result || o.flags !== e.flags || o.illegal !== e.illegal) begin
        bad++;
        $display("FAIL b2b_item got rd=%0d res=%h fl=%b ill=%b want rd=%0d res=%h fl=%b ill=%b spur=%0d",
                 o.rd, o.result, o.flags, o.illegal, e.rd, e.result, e.flags, e.illegal, e.spurious);
      end
    end
    exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_random();
    bit done;
    int n_cmp;
    rec_t e;
    rec_t o;
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [63:0] a, b, im;
    done = 0;
    n_cmp = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          rand_op(opc, f3, f7, a, b, im);
          drive_op(opc, f3, f7, a, b, im, 5'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain_queues(50);
    total++;
    if (pend_q.size() != 0 || obs_done.size() != 60) begin
      bad++;
      $display("FAIL rand_count got %0d outputs pending %0d want 60/0", obs_done.size(), pend_q.size());
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      e = exp_done.pop_front();
      o = obs_done.pop_front();
      total++;
      n_cmp++;
      if (e.spurious || o.rd !== e.rd || o.result !== e.result || o.flags !== e.flags || o.illegal !== e.illegal) begin
        bad++;
        $display("FAIL rand_item%0d got rd=%0d res=%h fl=%b ill=%b want rd=%0d res=%h fl=%b ill=%b spur=%0d",
                 n_cmp, o.rd, o.result, o.flags, o.illegal, e.rd, e.result, e.flags, e.illegal, e.spurious);
      end
    end
    exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_op(T_OP, 3'd4, 7'h00, 64'hAA, 64'h55, 64'd0, 5'd1);
    drive_op(T_OP, 3'd6, 7'h00, 64'hA0, 64'h05, 64'd0, 5'd2);
    // Both stages full; flush with a fresh op offered and downstream ready
    in_opcode = T_OP; in_funct3 = 3'd0; in_funct7 = 7'h00;
    in_rs1_val = 64'd1; in_rs2_val = 64'd2; in_rd = 5'd9;
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || obs_done.size() != 0) begin
      bad++;
      $display("FAIL flush_drop out_valid=%b delivered=%0d want 0/0", out_valid, obs_done.size());
    end
    pend_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive_op(T_OP, 3'd0, 7'h00, 64'd100, 64'd1, 64'd0, 5'd7);
    drive_op(T_OP, 3'd0, 7'h00, 64'd200, 64'd2, 64'd0, 5'd8);
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'd0) begin
      bad++;
      $display("FAIL async_rst out_valid=%b in_ready=%b res=%h want 0/1/0", out_valid, in_ready, out_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pend_q.delete(); exp_done.delete(); obs_done.delete();
    drive_op(T_OPI, 3'd0, 7'h7F, 64'd40, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd12);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_early out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'd38 || out_rd !== 5'd12 || out_flags !== 3'b100) begin
      bad++;
      $display("FAIL post_rst_op v=%b res=%0d rd=%0d fl=%b want 1/38/12/100", out_valid, out_result, out_rd, out_flags);
    end
    @(posedge clk); #1;
    pend_q.delete(); exp_done.delete(); obs_done.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
